alu_main: RTL and testbench



---
 rtl/alu_main.sv | 116 +++++++++++
 tb/tb_alu_main.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_main.sv
// Registered 8-bit ALU with an OFF/IDLE/LOAD/EXEC sequencer.
// Optional feature: define ALU_MUL_EN to build the multiplier. Without it, MUL yields 0x00.
module alu_main (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic [2:0] in_sel,
    input  logic [7:0] num1,
    input  logic [7:0] num2,
    input  logic [6:0] out_sel,
    output logic [7:0] out,
    output logic [1:0] currState,
    output logic [1:0] nextState
);

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_IDLE = 2'b01;
    localparam logic [1:0] ST_LOAD = 2'b10;
    localparam logic [1:0] ST_EXEC = 2'b11;

    logic [1:0] state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] r_q, r_d;
    logic       cmd_reset, cmd_load, cmd_persist;

    // Highest set bit of sel wins; no bit set gives zero.
    function automatic logic [7:0] alu_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [6:0] sel);
        logic [7:0] res;
        res = 8'h00;
        if (sel[6]) begin
            res = a + b;
        end else if (sel[5]) begin
            res = a - b;
        end else if (sel[4]) begin
`ifdef ALU_MUL_EN
            res = a * b;
`else
            res = 8'h00;
`endif
        end else if (sel[3]) begin
            res = (b == 8'h00) ? 8'hFF : a / b;
        end else if (sel[2]) begin
            res = a & b;
        end else if (sel[1]) begin
            res = a | b;
        end else if (sel[0]) begin
            res = a ^ b;
        end
        return res;
    endfunction

    always_comb begin
        cmd_reset   = in_sel[0];
        cmd_load    = ~in_sel[0] & in_sel[1];
        cmd_persist = ~in_sel[0] & ~in_sel[1] & (in_sel[2] | ~|in_sel);
    end

    always_comb begin
        state_d = state_q;
        if (!on) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:  state_d = ST_IDLE;
                ST_IDLE: begin
                    if (cmd_reset)        state_d = ST_IDLE;
                    else if (cmd_load)    state_d = ST_LOAD;
                    else if (cmd_persist) state_d = ST_IDLE;
                    else                  state_d = ST_IDLE;
                end
                ST_LOAD: state_d = cmd_reset ? ST_IDLE : ST_EXEC;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: turning off only clears the result; operands survive.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        if (!on) begin
            r_d = 8'h00;
        end else if (state_q != ST_OFF && cmd_reset) begin
            a_d = 8'h00;
            b_d = 8'h00;
            r_d = 8'h00;
        end else if (state_q == ST_LOAD) begin
            a_d = num1;
            b_d = num2;
        end else if (state_q == ST_EXEC) begin
            r_d = alu_op(a_q, b_q, out_sel);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_OFF;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            r_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
        end
    end

    assign out       = r_q;
    assign currState = state_q;
    assign nextState = state_d;

endmodule

// File: tb/tb_alu_main.sv
// Directed bench for alu_main: expected results go through a scoreboard queue
// and are popped when the sequencer returns from EXEC to IDLE.
module tb_alu_main;

    logic       clk = 1'b0;
    logic       rst;
    logic       on;
    logic [2:0] in_sel;
    logic [7:0] num1, num2;
    logic [6:0] out_sel;
    logic [7:0] out;
    logic [1:0] currState, nextState;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    localparam logic [6:0] OP_ADD = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_MUL = 7'b0010000;
    localparam logic [6:0] OP_DIV = 7'b0001000;
    localparam logic [6:0] OP_AND = 7'b0000100;
    localparam logic [6:0] OP_OR  = 7'b0000010;
    localparam logic [6:0] OP_XOR = 7'b0000001;

    alu_main dut (
        .clk(clk), .rst(rst), .on(on), .in_sel(in_sel),
        .num1(num1), .num2(num2), .out_sel(out_sel),
        .out(out), .currState(currState), .nextState(nextState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one load from IDLE, disturb operands after capture, then check the result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [6:0] sel, input logic [7:0] exp);
        logic seen = 1'b0;
        logic done = 1'b0;
        logic [7:0] e;
        num1 = a; num2 = b; out_sel = sel; in_sel = 3'b010;
        sb_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (currState == 2'b11) begin
                in_sel = 3'b100;
                num1 = ~a;
                num2 = 8'h00;
                seen = 1'b1;
            end else if (seen && currState == 2'b01) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 8'(done), 8'h01);
        e = sb_q.pop_front();
        chk(tag, out, e);
    endtask

    initial begin
        rst = 1'b0; on = 1'b0; in_sel = 3'b000;
        num1 = 8'h00; num2 = 8'h00; out_sel = 7'b0;
        #1;
        chk("rst_out", out, 8'h00);
        chk("rst_state", 8'(currState), 8'h00);
        chk("rst_next_off", 8'(nextState), 8'h00);
        on = 1'b1;
        #1;
        chk("rst_next_on", 8'(nextState), 8'h01);

        // Bring-up sequence with load held: OFF, IDLE, LOAD, EXEC, IDLE.
        @(negedge clk);
        rst = 1'b1; in_sel = 3'b010; num1 = 8'h02; num2 = 8'h04; out_sel = OP_ADD;
        sb_q.push_back(8'h06);
        chk("seq0", 8'(currState), 8'h00);
        @(negedge clk); chk("seq1", 8'(currState), 8'h01);
        @(negedge clk); chk("seq2", 8'(currState), 8'h02);
        @(negedge clk); chk("seq3", 8'(currState), 8'h03);
        in_sel = 3'b100;
        @(negedge clk); chk("seq4", 8'(currState), 8'h01);
        chk("first_add", out, sb_q.pop_front());

        run_op("add", 8'h57, 8'h1A, OP_ADD, 8'h71);
        run_op("sub", 8'h57, 8'h1A, OP_SUB, 8'h3D);
`ifdef ALU_MUL_EN
        run_op("mul", 8'h57, 8'h1A, OP_MUL, 8'hD6);
`else
        run_op("mul", 8'h57, 8'h1A, OP_MUL, 8'h00);
`endif
        run_op("div", 8'h57, 8'h1A, OP_DIV, 8'h03);
        run_op("and", 8'h57, 8'h1A, OP_AND, 8'h12);
        run_op("or",  8'h57, 8'h1A, OP_OR,  8'h5F);
        run_op("sub_wrap", 8'h1A, 8'h57, OP_SUB, 8'hC3);
        run_op("div0", 8'h80, 8'h00, OP_DIV, 8'hFF);
        run_op("add_wrap", 8'hFF, 8'h01, OP_ADD, 8'h00);
        run_op("xor", 8'h57, 8'h1A, OP_XOR, 8'h4D);

        in_sel = 3'b100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("persist_state", 8'(currState), 8'h01);
            chk("persist_out", out, 8'h4D);
        end

        // Reset command while in EXEC aborts and clears.
        num1 = 8'h57; num2 = 8'h1A; out_sel = OP_ADD; in_sel = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_exec", 8'(currState), 8'h03);
        in_sel = 3'b001;
        #1;
        chk("abort_next", 8'(nextState), 8'h01);
        @(negedge clk);
        chk("abort_state", 8'(currState), 8'h01);
        chk("abort_out", out, 8'h00);
        on = 1'b0;
        #1;
        chk("off_next", 8'(nextState), 8'h00);
        @(negedge clk);
        chk("off_state", 8'(currState), 8'h00);
        on = 1'b1; in_sel = 3'b100;
        @(negedge clk);
        chk("on_idle", 8'(currState), 8'h01);

        run_op("multi_hot", 8'h57, 8'h1A, 7'b1100000, 8'h71);
        run_op("sel_zero", 8'h57, 8'h1A, 7'b0000000, 8'h00);
        run_op("add_again", 8'h57, 8'h1A, OP_ADD, 8'h71);

        // Dropping on in LOAD abandons the operation and clears R.
        in_sel = 3'b010;
        @(negedge clk);
        chk("drop_in_load", 8'(currState), 8'h02);
        on = 1'b0;
        @(negedge clk);
        chk("drop_state", 8'(currState), 8'h00);
        chk("drop_out", out, 8'h00);
        on = 1'b1; in_sel = 3'b100;
        @(negedge clk);

        run_op("xor2", 8'h57, 8'h1A, OP_XOR, 8'h4D);
        in_sel = 3'b001;
        @(negedge clk);
        chk("idle_clr_state", 8'(currState), 8'h01);
        chk("idle_clr_out", out, 8'h00);

        run_op("or2", 8'h57, 8'h1A, OP_OR, 8'h5F);
        // Asynchronous reset between edges takes effect at once.
        in_sel = 3'b010;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_out", out, 8'h00);
        chk("async_state", 8'(currState), 8'h00);
        chk("sb_empty", 8'(sb_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
